// File: rtl/lcd_dbg_probe_pkg.sv
// Shared types and constants for the LCD debug probe: sampling FSM encoding,
// mode constants, default timing values and the wrapping cursor step.
package lcd_dbg_probe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_LATCH   = 2'd3
    } state_t;

    localparam logic MODE_RAM = 1'b1;
    localparam logic MODE_CPU = 1'b0;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_REFRESH_CYCLES  = 2500000;

    // Step a cursor by one in either direction, wrapping between 0 and last.
    function automatic logic [7:0] wrap_step(input logic [7:0] cur,
                                             input logic [7:0] last,
                                             input logic       up);
        if (up)
            return (cur == last) ? 8'd0 : cur + 8'd1;
        else
            return (cur == 8'd0) ? last : cur - 8'd1;
    endfunction

endpackage

// File: rtl/lcd_dbg_probe_if.sv
// RAM read port plus the address/data/mode triple handed to the LCD driver.
interface lcd_dbg_probe_if;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rd_data;
    logic [7:0] addr_out;
    logic [7:0] data_out;
    logic       switch_flag;

    modport master (
        output mem_addr, mem_rd_en, addr_out, data_out, switch_flag,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr, mem_rd_en, addr_out, data_out, switch_flag,
        output mem_rd_data
    );
endinterface

// File: rtl/lcd_dbg_probe_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, and a
// one-cycle pulse on each accepted 0->1 transition of the stable level.
module btn_debounce
    import lcd_dbg_probe_pkg::*;
#(
    parameter int CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(CYCLES - 1)) begin
                level_reg <= sync2_reg;
                press_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/lcd_dbg_probe.sv
// Browse cursor and mode selection for the LCD debug view; fetches the byte
// under the cursor from RAM or the CPU snapshot and holds it for display.
module lcd_dbg_probe
    import lcd_dbg_probe_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REFRESH_CYCLES  = DEF_REFRESH_CYCLES,
    parameter int RAM_LATENCY     = 1,
    parameter int CPU_BYTES       = 10
) (
    input  logic                   qzt_clk,
    input  logic                   rst_n,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_mode,
    input  logic [8*CPU_BYTES-1:0] cpu_interface,
    lcd_dbg_probe_if.master        bus
);
    localparam int         RW       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [7:0] CPU_LAST = 8'(CPU_BYTES - 1);

    logic [2:0] raw_btn;
    logic [2:0] press;

    assign raw_btn = {btn_mode, btn_down, btn_up};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk   (qzt_clk),
            .rst_n (rst_n),
            .raw   (raw_btn[gi]),
            .press (press[gi])
        );
    end

    // A mode press swallows up/down; simultaneous up and down cancel.
    logic mode_ev, up_ev, down_ev, any_ev;
    assign mode_ev = press[2];
    assign up_ev   = press[0] & ~press[1] & ~mode_ev;
    assign down_ev = press[1] & ~press[0] & ~mode_ev;
    assign any_ev  = mode_ev | up_ev | down_ev;

    state_t          state_reg, state_next;
    logic            switch_reg;
    logic [7:0]      ram_cur_reg, cpu_cur_reg;
    logic [RW-1:0]   refresh_reg;
    logic            pending_reg;
    logic [7:0]      mem_addr_reg, addr_reg, data_reg;
    logic [1:0]      wait_reg;
    logic            refresh_wrap;
    logic            rd_en, start_read, capture_ram, capture_cpu;
    logic [7:0]      cpu_byte;

    assign refresh_wrap = (refresh_reg == RW'(REFRESH_CYCLES - 1));

    always_comb begin
        cpu_byte = 8'd0;
        for (int k = 0; k < CPU_BYTES; k++) begin
            if (cpu_cur_reg == 8'(k))
                cpu_byte = cpu_interface[8*k +: 8];
        end
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pending_reg)
                    state_next = (switch_reg == MODE_CPU) ? ST_LATCH : ST_RD_REQ;
            end
            ST_RD_REQ:  state_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (wait_reg == 2'(RAM_LATENCY - 1))
                    state_next = ST_LATCH;
            end
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs load on the edge that enters LATCH, so the mode that chose the
    // path at IDLE decides the source even if switch_flag has since toggled.
    always_comb begin
        rd_en       = (state_reg == ST_RD_REQ);
        start_read  = (state_reg == ST_IDLE) && (state_next == ST_RD_REQ);
        capture_ram = (state_reg == ST_RD_WAIT) && (state_next == ST_LATCH);
        capture_cpu = (state_reg == ST_IDLE) && (state_next == ST_LATCH);
    end

    always_ff @(posedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_reg   <= MODE_RAM;
            ram_cur_reg  <= 8'd0;
            cpu_cur_reg  <= 8'd0;
            refresh_reg  <= '0;
            pending_reg  <= 1'b1;
            mem_addr_reg <= 8'd0;
            addr_reg     <= 8'd0;
            data_reg     <= 8'd0;
            wait_reg     <= 2'd0;
        end else begin
            if (mode_ev)
                switch_reg <= ~switch_reg;
            if (up_ev || down_ev) begin
                if (switch_reg == MODE_RAM)
                    ram_cur_reg <= wrap_step(ram_cur_reg, 8'hFF, up_ev);
                else
                    cpu_cur_reg <= wrap_step(cpu_cur_reg, CPU_LAST, up_ev);
            end
            refresh_reg <= refresh_wrap ? '0 : refresh_reg + RW'(1);
            if (any_ev || refresh_wrap)
                pending_reg <= 1'b1;
            else if (state_reg == ST_IDLE)
                pending_reg <= 1'b0;
            if (start_read)
                mem_addr_reg <= ram_cur_reg;
            if (capture_ram) begin
                addr_reg <= mem_addr_reg;
                data_reg <= bus.mem_rd_data;
            end else if (capture_cpu) begin
                addr_reg <= cpu_cur_reg;
                data_reg <= cpu_byte;
            end
            wait_reg <= (state_reg == ST_RD_WAIT) ? wait_reg + 2'd1 : 2'd0;
        end
    end

    assign bus.mem_addr    = mem_addr_reg;
    assign bus.mem_rd_en   = rd_en;
    assign bus.addr_out    = addr_reg;
    assign bus.data_out    = data_reg;
    assign bus.switch_flag = switch_reg;

endmodule

// File: tb/tb_lcd_dbg_probe.sv
// Randomized bench for lcd_dbg_probe against a cursor/mode model and a
// RAM model that returns ~addr unless a test rewrites a location.
`timescale 1ns/1ps
module tb_lcd_dbg_probe;
    localparam int NB = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0;
    logic [8*NB-1:0] cpu_interface;
    logic [7:0] cpu_bytes [NB];
    logic [7:0] ram [256];
    logic [7:0] ram_q;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int cycle = 0;
    int rd_base = 0;
    int m_ram = 0;
    int m_cpu = 0;
    bit m_mode = 1'b1;

    lcd_dbg_probe_if bus();

    lcd_dbg_probe #(
        .DEBOUNCE_CYCLES (4),
        .REFRESH_CYCLES  (64),
        .RAM_LATENCY     (1),
        .CPU_BYTES       (NB)
    ) dut (
        .qzt_clk       (clk),
        .rst_n         (rst_n),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_mode      (btn_mode),
        .cpu_interface (cpu_interface),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (bus.mem_rd_en === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            ram_q  <= ram[bus.mem_addr];
        end
    end

    assign bus.mem_rd_data = ram_q;

    always_comb begin
        cpu_interface = '0;
        for (int k = 0; k < NB; k++)
            cpu_interface[8*k +: 8] = cpu_bytes[k];
    end

    function automatic logic [7:0] exp_addr();
        return m_mode ? 8'(m_ram) : 8'(m_cpu);
    endfunction

    function automatic logic [7:0] exp_data();
        return m_mode ? ram[m_ram] : cpu_bytes[m_cpu];
    endfunction

    // which: 0 up, 1 down, 2 mode, 3 up+down together
    function automatic void model_apply(input int which);
        case (which)
            0: if (m_mode) m_ram = (m_ram + 1) % 256; else m_cpu = (m_cpu + 1) % NB;
            1: if (m_mode) m_ram = (m_ram + 255) % 256; else m_cpu = (m_cpu + NB - 1) % NB;
            2: m_mode = !m_mode;
            default: ;
        endcase
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
        repeat (3) @(negedge clk);
        m_ram = 0; m_cpu = 0; m_mode = 1'b1;
        rd_base = rd_cnt;
        rst_n = 1'b1;
    endtask

    task automatic press(input int which);
        @(negedge clk);
        btn_up   = (which == 0 || which == 3);
        btn_down = (which == 1 || which == 3);
        btn_mode = (which == 2);
        repeat (10) @(negedge clk);
        btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        model_apply(which);
    endtask

    task automatic wait_rd(input int limit, output bit seen);
        int n = 0;
        while (bus.mem_rd_en !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        seen = (bus.mem_rd_en === 1'b1);
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_rd_en, bus.switch_flag, bus.addr_out, bus.data_out, bus.mem_addr} !== {1'b0, 1'b1, 24'h0}) begin
            errors++;
            $display("FAIL reset_values: rd_en=%b sw=%b addr=%02h data=%02h mem_addr=%02h, want 0 1 00 00 00",
                     bus.mem_rd_en, bus.switch_flag, bus.addr_out, bus.data_out, bus.mem_addr);
        end
        apply_reset();
        wait_rd(10, seen);
        checks++;
        if (!seen || bus.mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL first_read: seen=%0b mem_addr=%02h, want 1 00", seen, bus.mem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL first_latency: data_out=%02h one cycle after rd_en, want 00", bus.data_out);
        end
        @(negedge clk);
        checks++;
        if (bus.addr_out !== exp_addr() || bus.data_out !== exp_data() || bus.switch_flag !== 1'b1) begin
            errors++;
            $display("FAIL first_sample: addr=%02h data=%02h sw=%b, want %02h %02h 1",
                     bus.addr_out, bus.data_out, bus.switch_flag, exp_addr(), exp_data());
        end
        $display("test_reset: addr=%02h data=%02h", bus.addr_out, bus.data_out);
    endtask

    task automatic test_ram_down();
        apply_reset();
        repeat (8) @(negedge clk);
        press(1);
        checks++;
        if (bus.addr_out !== 8'hFF || bus.data_out !== 8'h00 || bus.mem_addr !== 8'hFF || bus.switch_flag !== 1'b1) begin
            errors++;
            $display("FAIL ram_down_wrap: addr=%02h data=%02h mem_addr=%02h sw=%b, want FF 00 FF 1",
                     bus.addr_out, bus.data_out, bus.mem_addr, bus.switch_flag);
        end
        $display("test_ram_down: addr=%02h data=%02h", bus.addr_out, bus.data_out);
    endtask

    task automatic test_bounce_up();
        apply_reset();
        repeat (8) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            btn_up = ((i / 2) % 2 == 0);
            @(negedge clk);
        end
        btn_up = 1'b1;
        repeat (10) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        model_apply(0);
        checks++;
        if (bus.addr_out !== 8'h01 || bus.data_out !== 8'hFE) begin
            errors++;
            $display("FAIL bounce_up: addr=%02h data=%02h, want 01 FE", bus.addr_out, bus.data_out);
        end
        checks++;
        if (rd_cnt - rd_base !== 2) begin
            errors++;
            $display("FAIL bounce_reads: reads=%0d, want 2", rd_cnt - rd_base);
        end
        $display("test_bounce_up: addr=%02h reads=%0d", bus.addr_out, rd_cnt - rd_base);
    endtask

    task automatic test_cpu_mode();
        int rd_snap;
        apply_reset();
        for (int k = 0; k < NB; k++) cpu_bytes[k] = 8'($urandom);
        cpu_bytes[9] = 8'hA5;
        repeat (8) @(negedge clk);
        press(0);
        press(2);
        rd_snap = rd_cnt;
        checks++;
        if (bus.switch_flag !== 1'b0 || bus.addr_out !== exp_addr() || bus.data_out !== exp_data()) begin
            errors++;
            $display("FAIL cpu_enter: sw=%b addr=%02h data=%02h, want 0 %02h %02h",
                     bus.switch_flag, bus.addr_out, bus.data_out, exp_addr(), exp_data());
        end
        press(1);
        checks++;
        if (bus.addr_out !== 8'h09 || bus.data_out !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_down_wrap: addr=%02h data=%02h, want 09 A5", bus.addr_out, bus.data_out);
        end
        repeat (70) @(negedge clk);
        checks++;
        if (rd_cnt !== rd_snap || bus.addr_out !== 8'h09 || bus.data_out !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_no_read: reads=%0d addr=%02h data=%02h, want 0 09 A5",
                     rd_cnt - rd_snap, bus.addr_out, bus.data_out);
        end
        press(2);
        checks++;
        if (bus.switch_flag !== 1'b1 || bus.addr_out !== 8'h01 || bus.data_out !== 8'hFE) begin
            errors++;
            $display("FAIL ram_cursor_kept: sw=%b addr=%02h data=%02h, want 1 01 FE",
                     bus.switch_flag, bus.addr_out, bus.data_out);
        end
        $display("test_cpu_mode: addr=%02h data=%02h sw=%b", bus.addr_out, bus.data_out, bus.switch_flag);
    endtask

    task automatic test_up_down_same();
        int c0;
        apply_reset();
        c0 = cycle;
        repeat (8) @(negedge clk);
        press(3);
        while (cycle < c0 + 50) @(negedge clk);
        checks++;
        if (rd_cnt - rd_base !== 1 || bus.addr_out !== 8'h00) begin
            errors++;
            $display("FAIL up_down_ignored: reads=%0d addr=%02h, want 1 00", rd_cnt - rd_base, bus.addr_out);
        end
        while (cycle < c0 + 72) @(negedge clk);
        checks++;
        if (rd_cnt - rd_base !== 2 || bus.addr_out !== 8'h00 || bus.data_out !== 8'hFF) begin
            errors++;
            $display("FAIL up_down_refresh: reads=%0d addr=%02h data=%02h, want 2 00 FF",
                     rd_cnt - rd_base, bus.addr_out, bus.data_out);
        end
        $display("test_up_down_same: reads=%0d addr=%02h", rd_cnt - rd_base, bus.addr_out);
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        apply_reset();
        repeat (8) @(negedge clk);
        press(0);
        btn_up = 1'b1;
        wait_rd(20, seen);
        checks++;
        if (!seen || bus.mem_addr !== 8'h02) begin
            errors++;
            $display("FAIL second_up_read: seen=%0b mem_addr=%02h, want 1 02", seen, bus.mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b0;
        btn_up = 1'b0;
        #1;
        checks++;
        if ({bus.mem_rd_en, bus.switch_flag, bus.addr_out, bus.data_out} !== {1'b0, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL mid_read_reset: rd_en=%b sw=%b addr=%02h data=%02h, want 0 1 00 00",
                     bus.mem_rd_en, bus.switch_flag, bus.addr_out, bus.data_out);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL restart_read: rd_en=%b mem_addr=%02h, want 1 00", bus.mem_rd_en, bus.mem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.addr_out !== 8'h00 || bus.data_out !== exp_data()) begin
            errors++;
            $display("FAIL restart_sample: addr=%02h data=%02h, want 00 %02h", bus.addr_out, bus.data_out, exp_data());
        end
        $display("test_reset_mid_read: addr=%02h data=%02h", bus.addr_out, bus.data_out);
    endtask

    task automatic test_refresh();
        bit seen;
        int c1;
        apply_reset();
        repeat (10) @(negedge clk);
        ram[0] = 8'($urandom_range(0, 254));
        checks++;
        if (bus.data_out !== 8'hFF) begin
            errors++;
            $display("FAIL hold_between: data=%02h, want FF", bus.data_out);
        end
        wait_rd(80, seen);
        c1 = cycle;
        @(negedge clk);
        wait_rd(80, seen);
        checks++;
        if (!seen || cycle - c1 !== 64) begin
            errors++;
            $display("FAIL refresh_period: seen=%0b period=%0d, want 1 64", seen, cycle - c1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.addr_out !== 8'h00 || bus.data_out !== ram[0]) begin
            errors++;
            $display("FAIL refresh_pickup: addr=%02h data=%02h, want 00 %02h", bus.addr_out, bus.data_out, ram[0]);
        end
        $display("test_refresh: period=%0d data=%02h", cycle - c1 - 2, bus.data_out);
    endtask

    task automatic test_random_browse();
        int op;
        apply_reset();
        repeat (8) @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            op = $urandom_range(0, 2);
            cpu_bytes[$urandom_range(0, NB - 1)] = 8'($urandom);
            press(op);
            checks++;
            if (bus.addr_out !== exp_addr() || bus.data_out !== exp_data() || bus.switch_flag !== m_mode) begin
                errors++;
                $display("FAIL random_op%0d: addr=%02h data=%02h sw=%b, want %02h %02h %b",
                         op, bus.addr_out, bus.data_out, bus.switch_flag, exp_addr(), exp_data(), m_mode);
            end
            $display("random op=%0d addr=%02h data=%02h sw=%b", op, bus.addr_out, bus.data_out, bus.switch_flag);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = ~8'(i);
        for (int k = 0; k < NB; k++) cpu_bytes[k] = 8'(k);
        test_reset();
        test_ram_down();
        test_bounce_up();
        test_cpu_mode();
        test_up_down_same();
        test_reset_mid_read();
        test_refresh();
        test_random_browse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_dbg_probe.md
Name: lcd_dbg_probe

Overview:
Upstream feeder of the LCD debug driver. It turns three raw pushbuttons into a browse cursor and selects RAM mode or CPU mode. It fetches the byte under the cursor from the RAM read port or from the CPU_interface snapshot. It then presents a stable addr_out/data_out/switch_flag triple, which the LCD driver renders as "MR aa dd" or "CP aa dd".

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a synchronized button must stay unchanged before its new level is accepted (10 ms at 50 MHz)
REFRESH_CYCLES, 2500000, period of automatic re-sampling of the displayed byte
RAM_LATENCY, 1, cycles from mem_rd_en to valid mem_rd_data (legal range 1..3)
CPU_BYTES, 10, number of bytes in cpu_interface; byte k = cpu_interface[8k+7:8k]

Ports:
qzt_clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
btn_up  in  1  raw pushbutton, asynchronous, active-high
btn_down  in  1  raw pushbutton, asynchronous, active-high
btn_mode  in  1  raw pushbutton, asynchronous, active-high
cpu_interface  in  8*CPU_BYTES  CPU register snapshot
mem_addr  out  8  RAM read address
mem_rd_en  out  1  RAM read strobe, one cycle
mem_rd_data  in  8  RAM read data
addr_out  out  8  displayed address or CPU byte index (to LCD addrInput)
data_out  out  8  displayed data byte (to LCD dataInput)
switch_flag  out  1  1 = RAM mode, 0 = CPU mode (to LCD switchFlag)

Behaviour:
- Reset (async, rst_n=0): addr_out=0, data_out=0, mem_addr=0, mem_rd_en=0, switch_flag=1. Both cursors=0, FSM=IDLE, refresh counter=0, pending=1, debounced levels=0.
- Buttons: each passes a 2-FF synchronizer, then a per-button counter. The stable level updates only after DEBOUNCE_CYCLES consecutive identical synchronized samples. A press event is a one-cycle pulse on the stable 0->1 edge. Release produces no event.
- Event resolution (same cycle):
  - mode event: toggles switch_flag; any up/down event in that cycle is ignored.
  - up and down together: both ignored.
  - Any accepted event sets pending.
- RAM cursor: 8-bit. up = +1 with wrap 255->0; down = -1 with wrap 0->255.
- CPU cursor: 0..CPU_BYTES-1. up wraps CPU_BYTES-1 -> 0; down wraps 0 -> CPU_BYTES-1.
- Each cursor keeps its value across mode toggles.
- Refresh counter: wraps at REFRESH_CYCLES-1 and sets pending on wrap.
- FSM states: IDLE, RD_REQ, RD_WAIT, LATCH.
  - IDLE, pending=1, switch_flag=1: go to RD_REQ; clear pending; capture the RAM cursor into mem_addr.
  - IDLE, pending=1, switch_flag=0: go to LATCH; clear pending.
  - RD_REQ: mem_rd_en=1 for exactly this cycle; next state is RD_WAIT.
  - RD_WAIT: stays RAM_LATENCY-1 cycles (0 allowed), then goes to LATCH.
  - LATCH: next state is IDLE. Captures the values below.
    - RAM mode: addr_out <= mem_addr, data_out <= mem_rd_data.
    - CPU mode: addr_out <= CPU cursor (zero-extended), data_out <= selected byte.
- Latency: with mem_rd_en high in cycle N, addr_out and data_out change together at the start of cycle N+RAM_LATENCY+1.
- addr_out and data_out never update in different cycles. Between LATCH pulses they are held.
- mem_addr is held constant from RD_REQ through LATCH.
- Cursor or mode change during a read: the read completes with the captured address. pending is set again, so a fresh sample follows immediately from IDLE.
- Mode toggled during a read: LATCH uses the mode captured at IDLE. switch_flag itself changes immediately.
- Reset asserted mid-read: all state returns to reset values at once; no partial latch. After release, the first sample starts in the next cycle (pending=1).

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/RD_REQ/RD_WAIT/LATCH, 2 bits);
  - the mode constants MODE_RAM=1 and MODE_CPU=0;
  - the default DEBOUNCE_CYCLES and REFRESH_CYCLES values.
- One sub-module, btn_debounce (synchronizer + counter + press pulse), is instantiated three times.

Test Plan:
(All tests with DEBOUNCE_CYCLES=4, REFRESH_CYCLES=64, RAM_LATENCY=1; RAM model returns data = ~addr.)
1. Release reset -> mem_rd_en pulse with mem_addr=0x00; two cycles later addr_out=0x00, data_out=0xFF, switch_flag=1.
2. Press btn_down clean for 10 cycles from reset state -> RAM cursor 0xFF; read issued; addr_out=0xFF, data_out=0x00.
3. Bounce btn_up (toggle every 2 cycles for 12 cycles, then hold 1) -> exactly one increment; addr_out=0x01, data_out=0xFE.
4. Press btn_mode, cpu_interface byte 9 = 0xA5, then btn_down -> switch_flag=0; addr_out=0x09, data_out=0xA5; no mem_rd_en pulse in CPU mode.
5. Debounced up and down events in the same cycle -> cursor unchanged; no event-triggered sample.
6. Assert rst_n=0 in the RD_WAIT cycle -> mem_rd_en=0, outputs 0, switch_flag=1 at once; a fresh read follows release. Separately, with no buttons pressed -> a re-sample occurs every 64 cycles and picks up changed RAM contents.
